// File: rtl/uvma_cvmcu_cpi_frame_gen_pkg.sv
// Shared types, constants and helpers for the CPI frame generator.
// The shadow config layout follows CFG_CNT_W / CFG_DATA_W, the default module widths.
package uvma_cvmcu_cpi_frame_gen_pkg;

  localparam int CFG_DATA_W = 10;
  localparam int CFG_CNT_W  = 12;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_LINE,
    ST_HBLANK,
    ST_VFP
  } state_e;

  typedef enum logic [1:0] {
    PAT_INCR,
    PAT_XCOORD,
    PAT_CONST,
    PAT_CHECKER
  } pattern_e;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]  width;
    logic [CFG_CNT_W-1:0]  height;
    logic [CFG_CNT_W-1:0]  hblank;
    logic [CFG_CNT_W-1:0]  vblank;
    logic [CFG_CNT_W-1:0]  vsync_len;
    pattern_e              pattern;
    logic [CFG_DATA_W-1:0] cval;
    logic                  continuous;
  } shadow_cfg_t;

  // MSB-first byte update, CCITT polynomial, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [CFG_DATA_W-1:0] pix_value(
    input pattern_e              pat,
    input logic [CFG_CNT_W-1:0]  x,
    input logic                  y0,
    input logic [CFG_DATA_W-1:0] p,
    input logic [CFG_DATA_W-1:0] cval
  );
    case (pat)
      PAT_INCR:   return p;
      PAT_XCOORD: return CFG_DATA_W'(x);
      PAT_CONST:  return cval;
      default:    return (x[0] ^ y0) ? '1 : '0;
    endcase
  endfunction

endpackage

// File: rtl/uvma_cvmcu_cpi_frame_gen_if.sv
// CPI pin bundle: the generator drives it (master), receivers/monitors observe it (slave).
interface uvma_cvmcu_cpi_frame_gen_if #(
  parameter int DATA_W = uvma_cvmcu_cpi_frame_gen_pkg::CFG_DATA_W
);
  logic              cpi_vsync;
  logic              cpi_href;
  logic [DATA_W-1:0] cpi_data;

  modport master (output cpi_vsync, output cpi_href, output cpi_data);
  modport slave  (input  cpi_vsync, input  cpi_href, input  cpi_data);
endinterface

// File: rtl/uvma_cvmcu_cpi_frame_gen_crc16.sv
// Serial-byte CRC-16/CCITT accumulator over the registered CPI pixel stream.
// init wins over en; the register clears to 0 under reset like every other output.
module uvma_cvmcu_cpi_frame_gen_crc16
  import uvma_cvmcu_cpi_frame_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc16_byte(crc_q, din);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/uvma_cvmcu_cpi_frame_gen.sv
// CPI camera-sensor frame source: VSYNC, back porch, LINE/HBLANK rows, front porch.
// Define UVMA_CVMCU_CPI_FRAME_GEN_CRC_EN to add frame_crc (CRC-16/CCITT of data[7:0] per href beat).
module uvma_cvmcu_cpi_frame_gen
  import uvma_cvmcu_cpi_frame_gen_pkg::*;
#(
  parameter int DATA_W = CFG_DATA_W,
  parameter int CNT_W  = CFG_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_height,
  input  logic [CNT_W-1:0]  cfg_hblank,
  input  logic [CNT_W-1:0]  cfg_vblank,
  input  logic [CNT_W-1:0]  cfg_vsync_len,
  input  logic [1:0]        cfg_pattern,
  input  logic [DATA_W-1:0] cfg_const,
  input  logic              cfg_continuous,
  uvma_cvmcu_cpi_frame_gen_if.master cpi,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
`ifdef UVMA_CVMCU_CPI_FRAME_GEN_CRC_EN
  ,
  output logic [15:0]       frame_crc
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] PIX_ONE = DATA_W'(1);

  state_e            state_q, state_d;
  shadow_cfg_t       shd_q, shd_d, cfg_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] p_q, p_d;

  logic              vsync_q, vsync_d, href_q, href_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              cfg_ok, first_line, frame_end;
  logic [CNT_W-1:0]  vs_last;

  always_comb begin
    cfg_in.width      = cfg_width;
    cfg_in.height     = cfg_height;
    cfg_in.hblank     = cfg_hblank;
    cfg_in.vblank     = cfg_vblank;
    cfg_in.vsync_len  = cfg_vsync_len;
    cfg_in.pattern    = pattern_e'(cfg_pattern);
    cfg_in.cval       = cfg_const;
    cfg_in.continuous = cfg_continuous;
  end

  assign cfg_ok  = (cfg_width != '0) && (cfg_height != '0);
  // A zero vsync length still produces a single sync cycle.
  assign vs_last = (shd_q.vsync_len == '0) ? '0 : shd_q.vsync_len - CNT_ONE;

  always_comb begin
    state_d    = state_q;
    shd_d      = shd_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    p_d        = p_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    first_line = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            shd_d   = cfg_in;
            state_d = ST_VSYNC;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_VSYNC: begin
        if (cnt_q == vs_last) begin
          cnt_d = '0;
          if (shd_q.vblank != '0) state_d = ST_VBP;
          else                    first_line = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_VBP: begin
        if (cnt_q == shd_q.vblank - CNT_ONE) first_line = 1'b1;
        else                                 cnt_d = cnt_q + CNT_ONE;
      end
      ST_LINE: begin
        p_d = p_q + PIX_ONE;
        if (x_q == shd_q.width - CNT_ONE) begin
          x_d = '0;
          if (y_q == shd_q.height - CNT_ONE) begin
            if (shd_q.vblank != '0) begin
              state_d = ST_VFP;
              cnt_d   = '0;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            y_d = y_q + CNT_ONE;
            // hblank==0 keeps the FSM in LINE, so href never drops between rows.
            if (shd_q.hblank != '0) begin
              state_d = ST_HBLANK;
              cnt_d   = '0;
            end
          end
        end else begin
          x_d = x_q + CNT_ONE;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == shd_q.hblank - CNT_ONE) state_d = ST_LINE;
        else                                 cnt_d = cnt_q + CNT_ONE;
      end
      ST_VFP: begin
        if (cnt_q == shd_q.vblank - CNT_ONE) frame_end = 1'b1;
        else                                 cnt_d = cnt_q + CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (first_line) begin
      state_d = ST_LINE;
      x_d     = '0;
      y_d     = '0;
      p_d     = '0;
    end

    if (frame_end) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
      if (shd_q.continuous && start) begin
        if (cfg_ok) begin
          shd_d   = cfg_in;
          state_d = ST_VSYNC;
          cnt_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Abort overrides everything, including a frame ending on the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      p_d     = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Pin values are decoded from the next state so they line up with state_q.
  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_LINE);
    busy_d  = (state_d != ST_IDLE);
    data_d  = href_d ? pix_value(shd_d.pattern, x_d, y_d[0], p_d, shd_d.cval) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shd_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cpi.cpi_vsync = vsync_q;
  assign cpi.cpi_href  = href_q;
  assign cpi.cpi_data  = data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign cfg_err       = err_q;

`ifdef UVMA_CVMCU_CPI_FRAME_GEN_CRC_EN
  // Reinit while vsync is visible keeps the last frame's CRC readable during
  // a continuous-mode frame_done, which coincides with the first vsync cycle.
  uvma_cvmcu_cpi_frame_gen_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (vsync_q),
    .en    (href_q),
    .din   (data_q[7:0]),
    .crc   (frame_crc)
  );
`endif

endmodule
